tc77_reader: RTL and testbench



---
 rtl/tc77_reader.sv | 128 ++++++++++++
 tb/tb_tc77_reader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tc77_reader.sv
// TC77 3-wire reader: one attempt costs 33*CLKDIV cycles with nCS low plus a 1-cycle evaluation; rejected frames are retried up to MAX_RETRY times.
// START is ignored while BUSY or DONE is high; defining TC77_ACCEPT_NEG_EN makes negative readings acceptable.
module tc77_reader #(
  parameter int CLKDIV    = 24,
  parameter int RETRY_GAP = 1024,
  parameter int MAX_RETRY = 7
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        START,
  output logic        nCS,
  output logic        SCK,
  input  logic        SIO,
  output logic        BUSY,
  output logic        DONE,
  output logic        TEMP_VALID,
  output logic [12:0] TEMP,
  output logic [8:0]  TEMP_DEG,
  output logic        ERR
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SCK_HI   = 3'd2;
  localparam logic [2:0] S_SCK_LO   = 3'd3;
  localparam logic [2:0] S_EVAL     = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam int CNT_MAX = (RETRY_GAP > CLKDIV) ? RETRY_GAP : CLKDIV;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RETRY_GAP - 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [15:0]   shreg;
  logic [3:0]    retry_cnt;
  logic          sio_meta, sio_sync;
  logic          div_done, gap_done, start_ok, frame_ok, retry_last;

  assign TEMP_DEG = TEMP[12:4];

  always_comb begin
    div_done   = (cnt == DIV_LAST);
    gap_done   = (cnt == GAP_LAST);
    start_ok   = START && !DONE;
    retry_last = (retry_cnt == 4'(MAX_RETRY));
`ifdef TC77_ACCEPT_NEG_EN
    frame_ok   = shreg[2];
`else
    // Enclosure never runs below 0 C, so a negative frame is treated as a glitch.
    frame_ok   = shreg[2] && !shreg[15];
`endif
    state_nxt  = state;
    case (state)
      S_IDLE:     if (start_ok) state_nxt = S_CS_SETUP;
      S_CS_SETUP: if (div_done) state_nxt = S_SCK_HI;
      S_SCK_HI:   if (div_done) state_nxt = S_SCK_LO;
      S_SCK_LO:   if (div_done) state_nxt = (bit_idx == 4'd15) ? S_EVAL : S_SCK_HI;
      S_EVAL:     state_nxt = (frame_ok || retry_last) ? S_IDLE : S_GAP;
      S_GAP:      if (gap_done) state_nxt = S_CS_SETUP;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      retry_cnt  <= '0;
      sio_meta   <= 1'b0;
      sio_sync   <= 1'b0;
      nCS        <= 1'b1;
      SCK        <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      TEMP_VALID <= 1'b0;
      TEMP       <= '0;
      ERR        <= 1'b0;
    end else begin
      sio_meta <= SIO;
      sio_sync <= sio_meta;
      state    <= state_nxt;
      // Pins are registered from the next state so they change cleanly with the FSM.
      nCS      <= !((state_nxt == S_CS_SETUP) || (state_nxt == S_SCK_HI) ||
                    (state_nxt == S_SCK_LO));
      SCK      <= (state_nxt == S_SCK_HI);
      BUSY     <= (state_nxt != S_IDLE);
      DONE     <= 1'b0;
      cnt      <= ((state_nxt != state) || (state == S_IDLE)) ? '0 : cnt + 1'b1;

      if ((state == S_IDLE) && start_ok) begin
        TEMP_VALID <= 1'b0;
        ERR        <= 1'b0;
        retry_cnt  <= '0;
      end

      if ((state_nxt == S_CS_SETUP) && (state != S_CS_SETUP)) begin
        bit_idx <= '0;
        shreg   <= '0;
      end

      if ((state == S_SCK_HI) && div_done)
        shreg <= {shreg[14:0], sio_sync};

      if ((state == S_SCK_LO) && div_done && (bit_idx != 4'd15))
        bit_idx <= bit_idx + 4'd1;

      if (state == S_EVAL) begin
        if (frame_ok) begin
          TEMP       <= shreg[15:3];
          TEMP_VALID <= 1'b1;
          DONE       <= 1'b1;
        end else if (retry_last) begin
          ERR        <= 1'b1;
          TEMP_VALID <= 1'b0;
          DONE       <= 1'b1;
        end else begin
          retry_cnt  <= retry_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tc77_reader.sv
// Bench for tc77_reader: behavioural TC77 sensor, bus monitor and a queue-based result scoreboard.
module tb_tc77_reader;

  localparam int CLKDIV    = 4;
  localparam int RETRY_GAP = 16;
  localparam int MAX_RETRY = 2;
  localparam int WIN_LEN   = 33 * CLKDIV;
`ifdef TC77_ACCEPT_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic        MCLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        SIO = 1'b0;
  logic        nCS, SCK, BUSY, DONE, TEMP_VALID, ERR;
  logic [12:0] TEMP;
  logic [8:0]  TEMP_DEG;

  tc77_reader #(.CLKDIV(CLKDIV), .RETRY_GAP(RETRY_GAP), .MAX_RETRY(MAX_RETRY)) dut (
    .MCLK(MCLK), .RST(RST), .START(START), .nCS(nCS), .SCK(SCK), .SIO(SIO),
    .BUSY(BUSY), .DONE(DONE), .TEMP_VALID(TEMP_VALID), .TEMP(TEMP),
    .TEMP_DEG(TEMP_DEG), .ERR(ERR)
  );

  always #5 MCLK = ~MCLK;

  typedef struct {
    logic [12:0] temp;
    logic [8:0]  deg;
    logic        valid;
    logic        err;
    int          attempts;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] fr[3];
  int          nf = 1;
  int          base = 0;
  logic [12:0] model_temp = '0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input int a);
    return fr[(a < nf) ? a : nf - 1];
  endfunction

  // Sensor: MSB appears when nCS falls, later bits follow each SCK falling edge.
  int          att_cnt = 0;
  int          bitpos = 15;
  logic [15:0] cur = '0;
  logic        s_cs_prev = 1'b1, s_sck_prev = 1'b0;
  always @(negedge MCLK) begin
    if (s_cs_prev === 1'b1 && nCS === 1'b0) begin
      cur = pick(att_cnt - base);
      att_cnt++;
      bitpos = 15;
      SIO = cur[15];
    end else if (nCS === 1'b0 && s_sck_prev === 1'b1 && SCK === 1'b0) begin
      if (bitpos > 0) bitpos--;
      SIO = cur[bitpos];
    end
    s_cs_prev = nCS;
    s_sck_prev = SCK;
  end

  // Bus monitor: window lengths, SCK pulses per window, retry gaps, BUSY length, DONE pulses.
  int   win_total = 0, win_ok = 0, gap_total = 0, gap_ok = 0, done_total = 0;
  int   low_len = 0, pulses = 0, gap_len = 0, busy_cnt = 0, busy_last = 0;
  logic m_cs_prev = 1'b1, m_sck_prev = 1'b0, m_busy_prev = 1'b0, in_gap = 1'b0;
  always @(negedge MCLK) begin
    if (m_cs_prev === 1'b1 && nCS === 1'b0) begin
      win_total++;
      if (in_gap) begin
        gap_total++;
        if (gap_len == RETRY_GAP + 1) gap_ok++;
      end
      in_gap = 1'b0;
      low_len = 0;
      pulses = 0;
    end
    if (nCS === 1'b0) begin
      low_len++;
      if (SCK === 1'b1 && m_sck_prev === 1'b0) pulses++;
    end
    if (m_cs_prev === 1'b0 && nCS === 1'b1) begin
      if (low_len == WIN_LEN && pulses == 16) win_ok++;
      in_gap = BUSY;
      gap_len = 0;
    end
    if (nCS === 1'b1) begin
      gap_len++;
      if (BUSY !== 1'b1) in_gap = 1'b0;
    end
    if (BUSY === 1'b1) busy_cnt++;
    else if (m_busy_prev === 1'b1) begin
      busy_last = busy_cnt;
      busy_cnt = 0;
    end
    if (DONE === 1'b1) done_total++;
    m_cs_prev = nCS;
    m_sck_prev = SCK;
    m_busy_prev = BUSY;
  end

  task automatic do_request(input logic [15:0] f0, f1, f2, input int n, input int extra_starts);
    exp_t e;
    exp_t got;
    logic acc;
    logic [15:0] f;
    int w0, ok0, g0, gok0, d0, cyc;
    fr[0] = f0; fr[1] = f1; fr[2] = f2; nf = n;
    base = att_cnt;
    acc = 1'b0;
    e.attempts = 0;
    for (int a = 0; a <= MAX_RETRY && !acc; a++) begin
      f = pick(a);
      e.attempts++;
      if (f[2] && (!f[15] || NEG_EN)) begin
        acc = 1'b1;
        model_temp = f[15:3];
      end
    end
    e.valid = acc;
    e.err   = !acc;
    e.temp  = model_temp;
    e.deg   = model_temp[12:4];
    sb.push_back(e);
    w0 = win_total; ok0 = win_ok; g0 = gap_total; gok0 = gap_ok; d0 = done_total;

    @(negedge MCLK) START = 1'b1;
    @(negedge MCLK) START = 1'b0;
    for (int k = 0; k < extra_starts; k++) begin
      @(negedge MCLK) START = 1'b1;
      @(negedge MCLK) START = 1'b0;
    end
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 5000) begin
      @(negedge MCLK);
      cyc++;
    end
    if (DONE !== 1'b1) begin
      check_eq("done_timeout", 32'(DONE), 32'd1);
      return;
    end
    got = sb.pop_front();
    check_eq("temp", 32'(TEMP), 32'(got.temp));
    check_eq("temp_deg", 32'(TEMP_DEG), 32'(got.deg));
    check_eq("temp_valid", 32'(TEMP_VALID), 32'(got.valid));
    check_eq("err", 32'(ERR), 32'(got.err));
    check_eq("busy_at_done", 32'(BUSY), 32'd0);
    // A START that lands on the DONE cycle must not open a new request.
    START = 1'b1;
    @(negedge MCLK) START = 1'b0;
    repeat (4) @(negedge MCLK);
    check_eq("windows", 32'(win_total - w0), 32'(got.attempts));
    check_eq("clean_windows", 32'(win_ok - ok0), 32'(got.attempts));
    check_eq("gaps", 32'(gap_total - g0), 32'(got.attempts - 1));
    check_eq("gap_len_ok", 32'(gap_ok - gok0), 32'(got.attempts - 1));
    check_eq("busy_len", 32'(busy_last),
             32'(got.attempts * (WIN_LEN + 1) + (got.attempts - 1) * RETRY_GAP));
    check_eq("done_pulses", 32'(done_total - d0), 32'd1);
    check_eq("idle_after_done", 32'({nCS, BUSY}), 32'b10);
  endtask

  initial begin
    int cyc;
    repeat (4) @(negedge MCLK);
    check_eq("rst_ncs", 32'(nCS), 32'd1);
    check_eq("rst_sck", 32'(SCK), 32'd0);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_valid", 32'(TEMP_VALID), 32'd0);
    check_eq("rst_temp", 32'(TEMP), 32'd0);
    check_eq("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    repeat (3) @(negedge MCLK);

    // Not ready (bit 3 set but bit 2 clear), negative, then a good +16 C frame.
    do_request(16'h0808, 16'hF804, 16'h0804, 3, 0);
    // Single good frame: +36 C.
    do_request(16'h1204, 16'h1204, 16'h1204, 1, 0);
    // Never ready: retry budget runs out, TEMP keeps the last reading.
    do_request(16'h1200, 16'h1200, 16'h1200, 1, 0);
    // -16 C: accepted only with negative readings enabled.
    do_request(16'hF804, 16'hF804, 16'hF804, 1, 0);
    // START hammered while busy.
    do_request(16'h0804, 16'h0804, 16'h0804, 1, 10);

    // Reset in the middle of a frame while bit 7 is clocked.
    fr[0] = 16'h0804; nf = 1; base = att_cnt;
    @(negedge MCLK) START = 1'b1;
    @(negedge MCLK) START = 1'b0;
    cyc = 0;
    while (!(nCS === 1'b0 && pulses == 8 && SCK === 1'b1) && cyc < 1000) begin
      @(negedge MCLK);
      cyc++;
    end
    check_eq("reach_bit7", 32'(pulses), 32'd8);
    RST = 1'b1;
    @(posedge MCLK);
    #1;
    check_eq("midrst_ncs", 32'(nCS), 32'd1);
    check_eq("midrst_sck", 32'(SCK), 32'd0);
    check_eq("midrst_busy", 32'(BUSY), 32'd0);
    @(negedge MCLK) RST = 1'b0;
    model_temp = '0;
    repeat (3) @(negedge MCLK);
    do_request(16'h0A3C, 16'h0A3C, 16'h0A3C, 1, 0);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
